// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller.
// Scans DIGITS digits one slot at a time and applies PWM brightness, leading-zero
// blanking and per-digit enables. New display values take effect only at a frame
// boundary, so a frame never mixes old and new values.
module seg7_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int SLOT_CYCLES = 50000,
    parameter int PWM_BITS    = 4,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [4*DIGITS-1:0]   DIGIT_VALUES,
    input  logic [DIGITS-1:0]     DP_IN,
    input  logic [DIGITS-1:0]     DIGIT_EN,
    input  logic                  LZ_BLANK,
    input  logic [PWM_BITS-1:0]   BRIGHTNESS,
    input  logic                  LOAD,
    output logic [DIGITS-1:0]     SEG_SELECT_OUT,
    output logic [7:0]            HEX_OUT,
    output logic                  FRAME_TICK
);

    localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // One full set of display settings; held twice (pending and active).
    typedef struct packed {
        logic [4*DIGITS-1:0] val;
        logic [DIGITS-1:0]   dp;
        logic [DIGITS-1:0]   en;
        logic                lz;
        logic [PWM_BITS-1:0] bright;
    } disp_regs_t;

    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    disp_regs_t          pend_q, pend_d;
    disp_regs_t          act_q, act_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic [7:0]          hex_q, hex_d;
    logic                tick_q, tick_d;

    logic                slot_tc;
    logic                wrap;

    // Active-high gfedcba segment pattern for a hex nibble.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'h3F;
            4'h1: seg_decode = 7'h06;
            4'h2: seg_decode = 7'h5B;
            4'h3: seg_decode = 7'h4F;
            4'h4: seg_decode = 7'h66;
            4'h5: seg_decode = 7'h6D;
            4'h6: seg_decode = 7'h7D;
            4'h7: seg_decode = 7'h07;
            4'h8: seg_decode = 7'h7F;
            4'h9: seg_decode = 7'h6F;
            4'hA: seg_decode = 7'h77;
            4'hB: seg_decode = 7'h7C;
            4'hC: seg_decode = 7'h39;
            4'hD: seg_decode = 7'h5E;
            4'hE: seg_decode = 7'h79;
            default: seg_decode = 7'h71;
        endcase
    endfunction

    assign slot_tc = (slot_q == SLOT_W'(SLOT_CYCLES - 1));
    assign wrap    = slot_tc && (idx_q == IDX_W'(DIGITS - 1));

    // Scan counters, pending capture and frame-synchronous active update.
    always_comb begin
        slot_d = slot_tc ? '0 : slot_q + 1'b1;
        idx_d  = idx_q;
        if (slot_tc) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        pwm_d  = pwm_q + 1'b1;
        pend_d = pend_q;
        if (LOAD) begin
            pend_d.val    = DIGIT_VALUES;
            pend_d.dp     = DP_IN;
            pend_d.en     = DIGIT_EN;
            pend_d.lz     = LZ_BLANK;
            pend_d.bright = BRIGHTNESS;
        end
        // A LOAD on the wrap edge lands in pending only; active takes the old pending.
        act_d  = wrap ? pend_q : act_q;
        tick_d = wrap;
    end

    // Pin values for the currently scanned digit, registered one cycle later.
    always_comb begin
        logic              zero_run;
        logic [DIGITS-1:0] lz_mask;
        logic [3:0]        cur_nib;
        logic              cur_dp;
        logic              cur_en;
        logic              cur_lz;
        logic              pwm_on;
        logic              visible;
        logic [DIGITS-1:0] sel_on;
        logic [7:0]        hex_on;

        // Digit i is a leading zero when it and every digit above it are zero.
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run & (act_q.val[4*i +: 4] == 4'h0);
            lz_mask[i] = (i > 0) && zero_run;
        end

        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_en  = 1'b0;
        cur_lz  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = act_q.val[4*i +: 4];
                cur_dp  = act_q.dp[i];
                cur_en  = act_q.en[i];
                cur_lz  = lz_mask[i];
            end
        end

        pwm_on  = (&act_q.bright) || (pwm_q < act_q.bright);
        visible = cur_en && !(act_q.lz && cur_lz) && pwm_on;

        sel_on = '0;
        hex_on = 8'h00;
        if (visible) begin
            sel_on = DIGITS'(1) << idx_q;
            hex_on = {cur_dp, seg_decode(cur_nib)};
        end
        sel_d = ACTIVE_LOW ? ~sel_on : sel_on;
        hex_d = ACTIVE_LOW ? ~hex_on : hex_on;
    end

    // State and output registers; reset aborts the scan and drops pending values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            slot_q <= '0;
            idx_q  <= '0;
            pwm_q  <= '0;
            pend_q <= '0;
            act_q  <= '0;
            sel_q  <= {DIGITS{ACTIVE_LOW}};
            hex_q  <= {8{ACTIVE_LOW}};
            tick_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            idx_q  <= idx_d;
            pwm_q  <= pwm_d;
            pend_q <= pend_d;
            act_q  <= act_d;
            sel_q  <= sel_d;
            hex_q  <= hex_d;
            tick_q <= tick_d;
        end
    end

    assign SEG_SELECT_OUT = sel_q;
    assign HEX_OUT        = hex_q;
    assign FRAME_TICK     = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: DIGITS=4, SLOT_CYCLES=20, PWM_BITS=4, active-low pins.
module tb_seg7_scan_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] DIGIT_VALUES;
    logic [3:0]  DP_IN;
    logic [3:0]  DIGIT_EN;
    logic        LZ_BLANK;
    logic [3:0]  BRIGHTNESS;
    logic        LOAD;
    logic [3:0]  SEG_SELECT_OUT;
    logic [7:0]  HEX_OUT;
    logic        FRAME_TICK;

    int total = 0;
    int bad   = 0;
    int sel_cnt = 0;
    int multi_sel = 0;

    seg7_scan_ctrl #(
        .DIGITS(4), .SLOT_CYCLES(20), .PWM_BITS(4), .ACTIVE_LOW(1'b1)
    ) dut (
        .CLK(CLK), .RESET(RESET), .DIGIT_VALUES(DIGIT_VALUES), .DP_IN(DP_IN),
        .DIGIT_EN(DIGIT_EN), .LZ_BLANK(LZ_BLANK), .BRIGHTNESS(BRIGHTNESS), .LOAD(LOAD),
        .SEG_SELECT_OUT(SEG_SELECT_OUT), .HEX_OUT(HEX_OUT), .FRAME_TICK(FRAME_TICK)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock; sample 1ns after the edge and keep select statistics.
    task automatic step();
        @(posedge CLK);
        #1;
        if (SEG_SELECT_OUT != 4'hF) sel_cnt++;
        if ($countones(~SEG_SELECT_OUT) > 1) multi_sel++;
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en,
                        input logic lz, input logic [3:0] br);
        DIGIT_VALUES = v;
        DP_IN        = dp;
        DIGIT_EN     = en;
        LZ_BLANK     = lz;
        BRIGHTNESS   = br;
        LOAD         = 1'b1;
        step();
        LOAD         = 1'b0;
    endtask

    // Step until FRAME_TICK is seen (bounded); n = cycles stepped.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!FRAME_TICK && n < 200);
        chk("tick_seen", FRAME_TICK, 1'b1);
    endtask

    // Called at the tick sample; checks mid-slot pins for each digit of the new frame.
    task automatic chk_frame(input string tag, input logic [7:0] h0, input logic [7:0] h1,
                             input logic [7:0] h2, input logic [7:0] h3, input logic [3:0] en);
        logic [7:0] hx [4];
        logic [3:0] esel;
        logic [7:0] ehex;
        hx = '{h0, h1, h2, h3};
        repeat (6) step();
        for (int d = 0; d < 4; d++) begin
            if (d > 0) repeat (20) step();
            esel = 4'hF;
            ehex = 8'hFF;
            if (en[d]) begin
                esel[d] = 1'b0;
                ehex    = hx[d];
            end
            chk($sformatf("%s_sel%0d", tag, d), SEG_SELECT_OUT, esel);
            chk($sformatf("%s_hex%0d", tag, d), HEX_OUT, ehex);
        end
    endtask

    initial begin
        int n;
        RESET = 1'b1; LOAD = 1'b0; DIGIT_VALUES = '0; DP_IN = '0;
        DIGIT_EN = '0; LZ_BLANK = 1'b0; BRIGHTNESS = '0;

        // Reset state
        repeat (3) step();
        chk("rst_sel", SEG_SELECT_OUT, 4'hF);
        chk("rst_hex", HEX_OUT, 8'hFF);
        chk("rst_tick", FRAME_TICK, 1'b0);
        RESET = 1'b0;
        step();
        chk("rel_sel", SEG_SELECT_OUT, 4'hF);

        // Loaded values stay invisible until the frame boundary
        sel_cnt = 0;
        load(16'h1A2F, 4'h0, 4'hF, 1'b0, 4'hF);
        wait_tick(n);
        chk("pre_frame_dark", sel_cnt, 0);
        step();
        chk("tick_width", FRAME_TICK, 1'b0);
        chk("frame0_sel", SEG_SELECT_OUT, 4'b1110);
        chk("frame0_hex", HEX_OUT, 8'h8E);
        wait_tick(n);
        chk_frame("val1a2f", 8'h8E, 8'hA4, 8'h88, 8'hF9, 4'hF);
        wait_tick(n);
        wait_tick(n);
        chk("tick_period", n, 80);

        // Leading-zero blanking and digit enables
        load(16'h0007, 4'h0, 4'hF, 1'b1, 4'hF);
        wait_tick(n);
        chk_frame("lz0007", 8'hF8, 8'hFF, 8'hFF, 8'hFF, 4'b0001);
        load(16'h0000, 4'h0, 4'hF, 1'b1, 4'hF);
        wait_tick(n);
        chk_frame("lz0000", 8'hC0, 8'hFF, 8'hFF, 8'hFF, 4'b0001);
        load(16'h0000, 4'b0001, 4'hF, 1'b1, 4'hF);
        wait_tick(n);
        chk_frame("lzdp", 8'h40, 8'hFF, 8'hFF, 8'hFF, 4'b0001);
        load(16'h1A2F, 4'h0, 4'b1010, 1'b0, 4'hF);
        wait_tick(n);
        chk_frame("en1010", 8'h8E, 8'hA4, 8'h88, 8'hF9, 4'b1010);

        // PWM duty: 4 of 16 cycles at brightness 4, none at 0
        load(16'h1A2F, 4'h0, 4'hF, 1'b0, 4'h4);
        wait_tick(n);
        step();
        sel_cnt = 0;
        repeat (16) step();
        chk("pwm4_d0", sel_cnt, 4);
        repeat (4) step();
        sel_cnt = 0;
        repeat (16) step();
        chk("pwm4_d1", sel_cnt, 4);
        load(16'h1A2F, 4'h0, 4'hF, 1'b0, 4'h0);
        wait_tick(n);
        sel_cnt = 0;
        repeat (80) step();
        chk("pwm0_dark", sel_cnt, 0);

        // Last LOAD in a frame wins; LOAD on the wrap edge waits a frame
        wait_tick(n);
        load(16'h1111, 4'h0, 4'hF, 1'b0, 4'hF);
        load(16'h2222, 4'h0, 4'hF, 1'b0, 4'hF);
        repeat (77) step();
        load(16'h3333, 4'h0, 4'hF, 1'b0, 4'hF);
        chk("wrap_coincident", FRAME_TICK, 1'b1);
        chk_frame("val2222", 8'hA4, 8'hA4, 8'hA4, 8'hA4, 4'hF);
        wait_tick(n);
        chk_frame("val3333", 8'hB0, 8'hB0, 8'hB0, 8'hB0, 4'hF);

        // Mid-frame reset with a pending load
        load(16'h5555, 4'h0, 4'hF, 1'b0, 4'hF);
        repeat (2) step();
        RESET = 1'b1;
        step();
        chk("midrst_sel", SEG_SELECT_OUT, 4'hF);
        chk("midrst_hex", HEX_OUT, 8'hFF);
        chk("midrst_tick", FRAME_TICK, 1'b0);
        step();
        RESET = 1'b0;
        sel_cnt = 0;
        wait_tick(n);
        chk("midrst_restart", n, 80);
        repeat (40) step();
        chk("midrst_dark", sel_cnt, 0);
        chk("midrst_hex_idle", HEX_OUT, 8'hFF);

        chk("one_hot_select", multi_sel, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
